// File: rtl/div_mon_pkg.sv
// div_mon_pkg
// Shared definitions for the divided-clock period monitor: the FSM state
// encoding and the default values of the monitor parameters.
package div_mon_pkg;

    localparam int unsigned CNT_W_DEF      = 16;
    localparam int unsigned LOCK_COUNT_DEF = 4;
    localparam int unsigned TOL_DEF        = 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } mon_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det
// Brings an asynchronous level into the clkin domain through two flops and
// keeps one history flop, so that single-cycle rise/fall strobes can be
// derived from the synchronized level.
// Ports:
//   clkin   - clock, rising edge
//   rst     - synchronous active-high reset
//   sig_i   - asynchronous input level
//   sync_o  - synchronized level (second synchronizer flop)
//   rise_o  - one-cycle strobe, synchronized level went 0 -> 1
//   fall_o  - one-cycle strobe, synchronized level went 1 -> 0
module sync_edge_det (
    input  logic clkin,
    input  logic rst,
    input  logic sig_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic sync1_q;
    logic sync2_q;
    logic sync3_q;

    // Synchronizer chain plus history flop.
    always_ff @(posedge clkin) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= sig_i;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign sync_o = sync2_q;
    assign rise_o = sync2_q & ~sync3_q;
    assign fall_o = ~sync2_q & sync3_q;

endmodule

// File: rtl/div_period_monitor.sv
// div_period_monitor
// Measures the period of a divided clock in clkin cycles, compares it with a
// programmed expected period and reports lock, mismatch (sticky err) and
// counter timeout.
// Ports:
//   clkin, rst          - clock / synchronous active-high reset
//   enable              - 0 holds the monitor in IDLE
//   sig_in              - divided clock under test (asynchronous data)
//   expected [CNT_W]    - expected period, used at each compare
//   err_clr             - pulse clearing the sticky err flag
//   period [CNT_W]      - last measured period
//   period_valid        - one-cycle pulse when period updates
//   locked              - LOCK_COUNT consecutive in-tolerance periods seen
//   err                 - sticky mismatch/timeout flag
//   timeout             - one-cycle pulse when the period counter saturates
//   high_time [CNT_W]   - cycles the input was high in the last period
//                         (only when DIV_MON_DUTY_EN is defined)
module div_period_monitor
    import div_mon_pkg::*;
#(
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned LOCK_COUNT = LOCK_COUNT_DEF,
    parameter int unsigned TOL        = TOL_DEF
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             enable,
    input  logic             sig_in,
    input  logic [CNT_W-1:0] expected,
    input  logic             err_clr,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             err,
    output logic             timeout
`ifdef DIV_MON_DUTY_EN
    ,
    output logic [CNT_W-1:0] high_time
`endif
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W:0]   DIFF_ONE = {{CNT_W{1'b0}}, 1'b1};
    localparam logic [CNT_W:0]   TOL_V    = (CNT_W+1)'(TOL);
    localparam logic [3:0]       LOCK_V   = 4'(LOCK_COUNT);

    mon_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       mcnt_q, mcnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             pv_q, pv_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic             timeout_q, timeout_d;
    logic             err_set_s;

    logic             sync2_s;
    logic             rise_s;
    logic             fall_s;
    logic [CNT_W:0]   diff_s;
    logic [CNT_W:0]   abs_diff_s;
    logic             match_s;

    sync_edge_det u_sync (
        .clkin  (clkin),
        .rst    (rst),
        .sig_i  (sig_in),
        .sync_o (sync2_s),
        .rise_o (rise_s),
        .fall_o (fall_s)
    );

    // Unsigned difference one bit wider than the counter, then magnitude.
    assign diff_s     = {1'b0, cnt_q} - {1'b0, expected};
    assign abs_diff_s = diff_s[CNT_W] ? (~diff_s + DIFF_ONE) : diff_s;
    assign match_s    = (abs_diff_s <= TOL_V);

    // Next-state, counter, compare/lock and error logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcnt_d    = mcnt_q;
        period_d  = period_q;
        pv_d      = 1'b0;
        locked_d  = locked_q;
        timeout_d = 1'b0;
        err_set_s = 1'b0;

        if (!enable) begin
            state_d  = ST_IDLE;
            cnt_d    = CNT_ZERO;
            mcnt_d   = 4'd0;
            locked_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARM;
                    cnt_d   = CNT_ZERO;
                end
                ST_ARM: begin
                    if (rise_s) begin
                        cnt_d   = CNT_ONE;
                        state_d = ST_MEASURE;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_MEASURE: begin
                    if (rise_s) begin
                        // A rise wins over saturation, so timeout and
                        // period_valid never coincide.
                        period_d = cnt_q;
                        pv_d     = 1'b1;
                        cnt_d    = CNT_ONE;
                        if (match_s) begin
                            if (mcnt_q < LOCK_V) begin
                                mcnt_d   = mcnt_q + 4'd1;
                                locked_d = (mcnt_q == (LOCK_V - 4'd1)) ? 1'b1 : locked_q;
                            end else begin
                                mcnt_d   = mcnt_q;
                                locked_d = 1'b1;
                            end
                        end else begin
                            mcnt_d    = 4'd0;
                            locked_d  = 1'b0;
                            err_set_s = 1'b1;
                        end
                    end else if (cnt_q == CNT_MAX) begin
                        timeout_d = 1'b1;
                        err_set_s = 1'b1;
                        locked_d  = 1'b0;
                        mcnt_d    = 4'd0;
                        cnt_d     = CNT_ZERO;
                        state_d   = ST_ARM;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    cnt_d    = CNT_ZERO;
                    mcnt_d   = 4'd0;
                    locked_d = 1'b0;
                end
            endcase
        end

        // A new error in the same cycle as err_clr keeps err set.
        if (err_set_s) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clkin) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= CNT_ZERO;
            mcnt_q    <= 4'd0;
            period_q  <= CNT_ZERO;
            pv_q      <= 1'b0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcnt_q    <= mcnt_d;
            period_q  <= period_d;
            pv_q      <= pv_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
        end
    end

    assign period       = period_q;
    assign period_valid = pv_q;
    assign locked       = locked_q;
    assign err          = err_q;
    assign timeout      = timeout_q;

`ifdef DIV_MON_DUTY_EN
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             unused_edge_s;

    // High-time counter runs alongside the period counter; the rise cycle
    // itself is high, so a new period starts the count at one.
    always_comb begin
        hcnt_d = hcnt_q;
        high_d = high_q;
        if (!enable || (state_q == ST_IDLE)) begin
            hcnt_d = CNT_ZERO;
        end else if (rise_s) begin
            hcnt_d = CNT_ONE;
            if (state_q == ST_MEASURE) begin
                high_d = hcnt_q;
            end else begin
                high_d = high_q;
            end
        end else begin
            hcnt_d = hcnt_q + {{(CNT_W-1){1'b0}}, sync2_s};
        end
    end

    // High-time registers.
    always_ff @(posedge clkin) begin
        if (rst) begin
            hcnt_q <= CNT_ZERO;
            high_q <= CNT_ZERO;
        end else begin
            hcnt_q <= hcnt_d;
            high_q <= high_d;
        end
    end

    assign high_time     = high_q;
    assign unused_edge_s = fall_s;
`else
    logic unused_edge_s;

    // The level and falling strobe are only consumed by the duty option.
    assign unused_edge_s = fall_s ^ sync2_s;
`endif

endmodule

// File: tb/tb_div_period_monitor.sv
// Directed bench for div_period_monitor (CNT_W=8, LOCK_COUNT=4, TOL=1).
module tb_div_period_monitor;

    localparam int W = 8;

    logic         clkin = 1'b0;
    logic         rst;
    logic         enable;
    logic         sig_in;
    logic [W-1:0] expected;
    logic         err_clr;
    logic [W-1:0] period;
    logic         period_valid;
    logic         locked;
    logic         err;
    logic         timeout;
`ifdef DIV_MON_DUTY_EN
    logic [W-1:0] high_time;
`endif

    int           n_chk = 0;
    int           n_err = 0;
    int           pv_cnt;
    int           to_cnt;
    int           both_cnt;
    int           to_step;
    logic [W-1:0] last_period;
    logic [W-1:0] last_high;
    logic         err_at_pv;

    div_period_monitor #(.CNT_W(W), .LOCK_COUNT(4), .TOL(1)) dut (
        .clkin        (clkin),
        .rst          (rst),
        .enable       (enable),
        .sig_in       (sig_in),
        .expected     (expected),
        .err_clr      (err_clr),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .err          (err),
        .timeout      (timeout)
`ifdef DIV_MON_DUTY_EN
        ,
        .high_time    (high_time)
`endif
    );

    always #5 clkin = ~clkin;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Drive one clkin cycle of sig_in, then sample outputs 1ns after the edge.
    task automatic step(input logic s);
        sig_in = s;
        @(posedge clkin);
        #1;
        if (period_valid) begin
            pv_cnt++;
            last_period = period;
            err_at_pv   = err;
`ifdef DIV_MON_DUTY_EN
            last_high = high_time;
`endif
        end
        if (timeout) to_cnt++;
        if (period_valid && timeout) both_cnt++;
    endtask

    task automatic wave(input int n, input int hi, input int lo);
        for (int p = 0; p < n; p++) begin
            for (int i = 0; i < hi; i++) step(1'b1);
            for (int i = 0; i < lo; i++) step(1'b0);
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; sig_in = 1'b0; err_clr = 1'b0; expected = 8'd16;
        pv_cnt = 0; to_cnt = 0; both_cnt = 0; to_step = -1;
        last_period = 8'd0; last_high = 8'd0; err_at_pv = 1'b0;

        repeat (3) step(1'b0);
        chk("rst_period", period, 0);
        chk("rst_flags", {period_valid, locked, err, timeout}, 0);

        // Nominal: toggle every 8 cycles, expected 16.
        rst = 1'b0; enable = 1'b1;
        step(1'b0); step(1'b0);
        pv_cnt = 0;
        wave(4, 8, 8);
        chk("pv_after_4_edges", pv_cnt, 3);
        chk("period_16", last_period, 16);
        chk("not_locked_3_matches", locked, 0);
        wave(1, 8, 8);
        chk("pv_after_5_edges", pv_cnt, 4);
        chk("locked_5th_edge", locked, 1);
        chk("no_err_nominal", err, 0);

        // Mismatch by 2 (> TOL).
        expected = 8'd18;
        wave(1, 8, 8);
        chk("mismatch_err", err, 1);
        chk("mismatch_unlock", locked, 0);

        // err_clr alone clears; next period sets again.
        for (int i = 0; i < 8; i++) step(1'b1);
        err_clr = 1'b1; step(1'b0); err_clr = 1'b0;
        chk("err_clr_clears", err, 0);
        for (int i = 0; i < 7; i++) step(1'b0);
        chk("err_clr_holds", err, 0);
        wave(1, 8, 8);
        chk("err_set_again", err, 1);

        // err_clr held across a mismatch: set wins at the compare.
        err_clr = 1'b1;
        wave(1, 8, 8);
        err_clr = 1'b0;
        chk("set_beats_clr", err_at_pv, 1);
        chk("clr_after_set", err, 0);

        // Difference of exactly TOL still matches.
        expected = 8'd17;
        wave(4, 8, 8);
        chk("tol_edge_locked", locked, 1);
        chk("tol_edge_no_err", err, 0);

        // Hold low: counter saturates 255 cycles after the last reset.
        pv_cnt = 0; to_cnt = 0;
        for (int h = 0; h < 300; h++) begin
            step(1'b0);
            if (timeout && (to_step < 0)) to_step = h;
        end
        chk("timeout_count", to_cnt, 1);
        chk("timeout_step", to_step, 241);
        chk("timeout_unlock", locked, 0);
        chk("timeout_err", err, 1);
        chk("timeout_no_pv", pv_cnt, 0);

        // Back in ARM: two edges give one period.
        expected = 8'd16;
        wave(2, 8, 8);
        chk("rearm_one_pv", pv_cnt, 1);
        chk("rearm_period", last_period, 16);

        // Enable dropped mid-period.
        pv_cnt = 0;
        for (int i = 0; i < 8; i++) step(1'b1);
        chk("pre_drop_pv", pv_cnt, 1);
        for (int i = 0; i < 4; i++) step(1'b0);
        enable = 1'b0;
        step(1'b0); step(1'b0);
        chk("disabled_unlock", locked, 0);
        enable = 1'b1;
        step(1'b0); step(1'b0);
        wave(1, 8, 8);
        chk("reenable_arm_only", pv_cnt, 1);
        wave(1, 8, 8);
        chk("reenable_pv", pv_cnt, 2);
        chk("reenable_period", last_period, 16);

        // Reset while locked with err set.
        wave(3, 8, 8);
        chk("pre_rst_locked", locked, 1);
        chk("pre_rst_err", err, 1);
        rst = 1'b1;
        step(1'b0);
        chk("mid_rst_period", period, 0);
        chk("mid_rst_flags", {period_valid, locked, err, timeout}, 0);
        rst = 1'b0;

`ifdef DIV_MON_DUTY_EN
        // 6-high / 10-low waveform.
        pv_cnt = 0;
        wave(3, 6, 10);
        chk("duty_period", last_period, 16);
        chk("duty_high_time", last_high, 6);
`endif

        chk("no_pv_with_timeout", both_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
